// File: rtl/mem_stage.sv
// mem_stage: memory-stage controller sitting between the X->M and M->W latches.
// Drives a multi-cycle data memory through a request/done handshake, stalls the
// pipeline while an access is outstanding, returns load data, flags misaligned
// accesses (sticky) and issues the single end-of-program dump request.
//
// Optional feature macro: MEM_STAGE_PERF_EN enables saturating load/store/stall
// performance counters; when undefined the counter outputs are tied to zero.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   dataAddrM         byte address of the access (held by X->M latch)
//   wrtDataM          store data
//   memWrtM, readEnM  store / load request (both high = store)
//   createDumpM       halt instruction is in M
//   mem_dataOut       memory read data, valid while mem_done
//   mem_done          access complete pulse
//   mem_busy          memory cannot accept a request this cycle
//   mem_addr          request address
//   mem_dataIn        request write data
//   mem_rd, mem_wr    one-cycle load / store request strobes
//   mem_createdump    one-cycle dump request strobe
//   readDataM         load result to the M->W latch
//   stallM            freeze upstream, bubble into M->W
//   errM              sticky misaligned-access flag
//   ldCount, stCount, stallCount  performance counters

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dataAddrM,
    input  logic [15:0] wrtDataM,
    input  logic        memWrtM,
    input  logic        readEnM,
    input  logic        createDumpM,
    input  logic [15:0] mem_dataOut,
    input  logic        mem_done,
    input  logic        mem_busy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dataIn,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_createdump,
    output logic [15:0] readDataM,
    output logic        stallM,
    output logic        errM,
    output logic [15:0] ldCount,
    output logic [15:0] stCount,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StHalt = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic [15:0] res_q, res_d;

    logic req, mis, is_load;

    assign req     = memWrtM | readEnM;
    assign mis     = req & dataAddrM[0];
    assign is_load = readEnM & ~memWrtM;

    // Request fields follow the latch directly; the stall keeps them stable in BUSY.
    assign mem_addr   = dataAddrM;
    assign mem_dataIn = wrtDataM;
    assign errM       = err_q;

    always_comb begin
        state_d        = state_q;
        err_d          = err_q;
        res_d          = res_q;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_createdump = 1'b0;
        stallM         = 1'b0;
        readDataM      = res_q;
        unique case (state_q)
            StIdle: begin
                if (mis) begin
                    // Retire without touching memory.
                    err_d     = 1'b1;
                    readDataM = 16'h0000;
                end else if (req) begin
                    if (mem_busy) begin
                        stallM = 1'b1;
                    end else begin
                        mem_rd = is_load;
                        mem_wr = memWrtM;
                        if (mem_done) begin
                            readDataM = mem_dataOut;
                            if (is_load) res_d = mem_dataOut;
                        end else begin
                            stallM  = 1'b1;
                            state_d = StBusy;
                        end
                    end
                end else if (createDumpM) begin
                    stallM = 1'b1;
                    if (!mem_busy) begin
                        mem_createdump = 1'b1;
                        state_d        = StHalt;
                    end
                end
            end
            StBusy: begin
                stallM = ~mem_done;
                if (mem_done) begin
                    readDataM = mem_dataOut;
                    if (is_load) res_d = mem_dataOut;
                    state_d = StIdle;
                end
            end
            StHalt: begin
                stallM = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
            res_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] ld_cnt_q, st_cnt_q, stall_cnt_q;
    logic [15:0] ld_cnt_d, st_cnt_d, stall_cnt_d;

    // Saturating increments.
    always_comb begin
        ld_cnt_d    = ld_cnt_q;
        st_cnt_d    = st_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (mem_rd && ld_cnt_q != 16'hFFFF) ld_cnt_d = ld_cnt_q + 16'd1;
        if (mem_wr && st_cnt_q != 16'hFFFF) st_cnt_d = st_cnt_q + 16'd1;
        if (stallM && state_q != StHalt && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt_q    <= 16'h0000;
            st_cnt_q    <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            ld_cnt_q    <= ld_cnt_d;
            st_cnt_q    <= st_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ldCount    = ld_cnt_q;
    assign stCount    = st_cnt_q;
    assign stallCount = stall_cnt_q;
`else
    assign ldCount    = 16'h0000;
    assign stCount    = 16'h0000;
    assign stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-cycle IDLE-state vectors
// plus hand-written sequences for misses, busy back-pressure, misalignment,
// halt and reset during an outstanding access.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dataAddrM, wrtDataM, mem_dataOut;
    logic        memWrtM, readEnM, createDumpM, mem_done, mem_busy;
    logic [15:0] mem_addr, mem_dataIn, readDataM, ldCount, stCount, stallCount;
    logic        mem_rd, mem_wr, mem_createdump, stallM, errM;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .dataAddrM      (dataAddrM),
        .wrtDataM       (wrtDataM),
        .memWrtM        (memWrtM),
        .readEnM        (readEnM),
        .createDumpM    (createDumpM),
        .mem_dataOut    (mem_dataOut),
        .mem_done       (mem_done),
        .mem_busy       (mem_busy),
        .mem_addr       (mem_addr),
        .mem_dataIn     (mem_dataIn),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_createdump (mem_createdump),
        .readDataM      (readDataM),
        .stallM         (stallM),
        .errM           (errM),
        .ldCount        (ldCount),
        .stCount        (stCount),
        .stallCount     (stallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] dout;
        logic        wr;
        logic        rd;
        logic        done;
        logic        busy;
        logic        e_rd;
        logic        e_wr;
        logic        e_stall;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] addr, input logic [15:0] wdata, input logic wr,
                         input logic rd, input logic dump, input logic [15:0] dout,
                         input logic done, input logic busy);
        dataAddrM   = addr;
        wrtDataM    = wdata;
        memWrtM     = wr;
        readEnM     = rd;
        createDumpM = dump;
        mem_dataOut = dout;
        mem_done    = done;
        mem_busy    = busy;
    endtask

    task automatic do_reset();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        //          addr      wdata     dout      wr rd dn bz  erd ewr est erdata
        vt[0] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
        vt[1] = '{16'h0010, 16'h0000, 16'hBEEF, 0, 1, 1, 0, 1, 0, 0, 16'hBEEF};
        vt[2] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF};
        vt[3] = '{16'h0020, 16'h00AA, 16'h5555, 1, 0, 1, 0, 0, 1, 0, 16'h5555};
        vt[4] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF};
        vt[5] = '{16'h0040, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 0, 1, 16'hBEEF};
        vt[6] = '{16'h0050, 16'h1357, 16'h1111, 1, 1, 1, 0, 0, 1, 0, 16'h1111};
        vt[7] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF};
        vt[8] = '{16'h0000, 16'h0000, 16'h7777, 0, 0, 1, 0, 0, 0, 0, 16'hBEEF};
        vt[9] = '{16'h0100, 16'h0000, 16'h0042, 0, 1, 1, 0, 1, 0, 0, 16'h0042};

        rst = 1'b1;
        do_reset();
        #3;
        chk("reset stall", {15'd0, stallM}, 16'd0);
        chk("reset err", {15'd0, errM}, 16'd0);
        chk("reset rdata", readDataM, 16'h0000);

        // Table: each vector stays in IDLE (hits, busy stalls, no-request cycles).
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].wr, vt[i].rd, 1'b0, vt[i].dout,
                  vt[i].done, vt[i].busy);
            #3;
            chk($sformatf("vec%0d mem_rd", i), {15'd0, mem_rd}, {15'd0, vt[i].e_rd});
            chk($sformatf("vec%0d mem_wr", i), {15'd0, mem_wr}, {15'd0, vt[i].e_wr});
            chk($sformatf("vec%0d stall", i), {15'd0, stallM}, {15'd0, vt[i].e_stall});
            chk($sformatf("vec%0d rdata", i), readDataM, vt[i].e_rdata);
            chk($sformatf("vec%0d addr", i), mem_addr, vt[i].addr);
            chk($sformatf("vec%0d dataIn", i), mem_dataIn, vt[i].wdata);
            tick();
        end

        // Load miss: done arrives 3 cycles after issue.
        do_reset();
        drive(16'h0030, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("miss issue rd", {15'd0, mem_rd}, 16'd1);
        chk("miss issue stall", {15'd0, stallM}, 16'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            #3;
            chk($sformatf("miss busy%0d rd", c), {15'd0, mem_rd}, 16'd0);
            chk($sformatf("miss busy%0d stall", c), {15'd0, stallM}, 16'd1);
        end
        tick();
        mem_done = 1'b1;
        mem_dataOut = 16'h1234;
        #3;
        chk("miss done stall", {15'd0, stallM}, 16'd0);
        chk("miss done rdata", readDataM, 16'h1234);
        chk("miss done rd", {15'd0, mem_rd}, 16'd0);
        tick();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("miss result reg", readDataM, 16'h1234);
        chk("miss back idle stall", {15'd0, stallM}, 16'd0);

        // Store held off by mem_busy for 2 cycles, then a 1-cycle miss.
        tick();
        drive(16'h0020, 16'h00AA, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #3;
            chk($sformatf("st busy%0d stall", c), {15'd0, stallM}, 16'd1);
            chk($sformatf("st busy%0d wr", c), {15'd0, mem_wr}, 16'd0);
            tick();
        end
        mem_busy = 1'b0;
        #3;
        chk("st issue wr", {15'd0, mem_wr}, 16'd1);
        chk("st issue addr", mem_addr, 16'h0020);
        chk("st issue dataIn", mem_dataIn, 16'h00AA);
        chk("st issue stall", {15'd0, stallM}, 16'd1);
        tick();
        mem_done = 1'b1;
        #3;
        chk("st busy wr", {15'd0, mem_wr}, 16'd0);
        chk("st done stall", {15'd0, stallM}, 16'd0);
        tick();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("st keeps result", readDataM, 16'h1234);

        // Misaligned load, then an aligned load hit.
        do_reset();
        drive(16'h0003, 16'h0, 1'b0, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
        #3;
        chk("mis rd", {15'd0, mem_rd}, 16'd0);
        chk("mis stall", {15'd0, stallM}, 16'd0);
        chk("mis rdata", readDataM, 16'h0000);
        tick();
        drive(16'h0004, 16'h0, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b1, 1'b0);
        #3;
        chk("mis err set", {15'd0, errM}, 16'd1);
        chk("after mis rd", {15'd0, mem_rd}, 16'd1);
        chk("after mis rdata", readDataM, 16'h4321);
        tick();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("mis err held", {15'd0, errM}, 16'd1);

        // Halt: dump waits for busy, pulses once, then stalls until reset.
        do_reset();
        chk("halt err cleared", {15'd0, errM}, 16'd0);
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1);
        #3;
        chk("dump busy pulse", {15'd0, mem_createdump}, 16'd0);
        chk("dump busy stall", {15'd0, stallM}, 16'd1);
        tick();
        mem_busy = 1'b0;
        #3;
        chk("dump pulse", {15'd0, mem_createdump}, 16'd1);
        tick();
        readEnM = 1'b1;
        mem_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("halt%0d dump", c), {15'd0, mem_createdump}, 16'd0);
            chk($sformatf("halt%0d stall", c), {15'd0, stallM}, 16'd1);
            chk($sformatf("halt%0d rd", c), {15'd0, mem_rd}, 16'd0);
            tick();
        end
        do_reset();
        #3;
        chk("halt reset stall", {15'd0, stallM}, 16'd0);

        // Perf: 2 loads, 1 store, 3 miss stall cycles.
        tick();
        do_reset();
        drive(16'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
        tick();
        drive(16'h0012, 16'h0055, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        drive(16'h0014, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        mem_done = 1'b1;
        mem_dataOut = 16'hCAFE;
        #3;
        chk("perf done rdata", readDataM, 16'hCAFE);
        tick();
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
`ifdef MEM_STAGE_PERF_EN
        chk("perf ldCount", ldCount, 16'd2);
        chk("perf stCount", stCount, 16'd1);
        chk("perf stallCount", stallCount, 16'd3);
`else
        chk("perf ldCount", ldCount, 16'd0);
        chk("perf stCount", stCount, 16'd0);
        chk("perf stallCount", stallCount, 16'd0);
`endif

        // Reset during BUSY abandons the access; a late done is ignored.
        tick();
        drive(16'h0060, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b0);
        #3;
        chk("rst busy stall", {15'd0, stallM}, 16'd0);
        chk("rst busy rdata", readDataM, 16'h0000);
        chk("rst busy ldCount", ldCount, 16'd0);
        chk("rst busy stCount", stCount, 16'd0);
        chk("rst busy stallCount", stallCount, 16'd0);
        tick();
        mem_done = 1'b0;
        #3;
        chk("rst busy late done", readDataM, 16'h0000);
        drive(16'h0070, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        #3;
        chk("rst busy new issue", {15'd0, mem_rd}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
